// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: op codes seen by the decoder/ALU
// and the FSM state encoding.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MUL  = 2'b00,
        MD_MULU = 2'b01,
        MD_DIV  = 2'b10,
        MD_DIVU = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Unsigned radix-2 non-restoring divider: one quotient bit per step, WIDTH steps.
// Outputs present the result of the step being taken this cycle, remainder already corrected.
module muldiv_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             last,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CNT_W = $clog2(WIDTH);

    // Partial remainder needs two bits of headroom: the shifted value spans [-2d, 2d).
    logic [WIDTH+1:0] rem_reg;
    logic [WIDTH+1:0] rem_shift;
    logic [WIDTH+1:0] rem_next;
    logic [WIDTH+1:0] div_ext;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] div_reg;
    logic [CNT_W-1:0] count_reg;

    always_comb begin
        div_ext   = {2'b00, div_reg};
        rem_shift = {rem_reg[WIDTH:0], quo_reg[WIDTH-1]};
        rem_next  = rem_reg[WIDTH+1] ? rem_shift + div_ext : rem_shift - div_ext;
        quo_next  = {quo_reg[WIDTH-2:0], ~rem_next[WIDTH+1]};
    end

    assign last      = (count_reg == CNT_W'(WIDTH - 1));
    assign quotient  = quo_next;
    // The true remainder lies in [0, d), so the low WIDTH bits of the fix-up suffice.
    assign remainder = rem_next[WIDTH+1] ? rem_next[WIDTH-1:0] + div_reg
                                         : rem_next[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_reg   <= '0;
            quo_reg   <= '0;
            div_reg   <= '0;
            count_reg <= '0;
        end else if (load) begin
            rem_reg   <= '0;
            quo_reg   <= dividend;
            div_reg   <= divisor;
            count_reg <= '0;
        end else if (step) begin
            rem_reg   <= rem_next;
            quo_reg   <= quo_next;
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide unit: pipelined signed/unsigned multiply, iterative
// divide with sign fix-up, pipeline stall generation and flush handling.
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             annul,
    output logic             busy,
    output logic             res_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import muldiv_pkg::*;

    localparam logic [1:0] MUL_LAST = 2'(MUL_STAGES > 1 ? MUL_STAGES - 2 : 0);

    md_state_e        state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             a_neg_reg;
    logic             q_neg_reg;
    logic             b_zero_reg;
    logic             res_valid_reg;
    logic [1:0]       mul_cnt_reg;

    logic             accept;
    logic             signed_op;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod_now;
    logic [2*WIDTH-1:0] prod_out;
    logic             div_last;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    assign accept    = (state_reg == ST_IDLE) && op_valid && !annul;
    assign signed_op = md_is_signed(op);

    always_comb begin
        a_abs    = (signed_op && a[WIDTH-1]) ? -a : a;
        b_abs    = (signed_op && b[WIDTH-1]) ? -b : b;
        a_ext    = {{WIDTH{signed_op & a[WIDTH-1]}}, a};
        b_ext    = {{WIDTH{signed_op & b[WIDTH-1]}}, b};
        prod_now = a_ext * b_ext;
    end

    // The product is formed from the live operands in the accept cycle, then delayed.
    genvar gi;
    generate
        if (MUL_STAGES > 1) begin : g_mul_pipe
            logic [2*WIDTH-1:0] pipe_reg [MUL_STAGES-1];
            for (gi = 0; gi < MUL_STAGES - 1; gi++) begin : g_stage
                if (gi == 0) begin : g_first
                    always_ff @(posedge clk) begin
                        if (rst) pipe_reg[gi] <= '0;
                        else     pipe_reg[gi] <= prod_now;
                    end
                end else begin : g_next
                    always_ff @(posedge clk) begin
                        if (rst) pipe_reg[gi] <= '0;
                        else     pipe_reg[gi] <= pipe_reg[gi-1];
                    end
                end
            end
            assign prod_out = pipe_reg[MUL_STAGES-2];
        end else begin : g_mul_comb
            assign prod_out = prod_now;
        end
    endgenerate

    muldiv_div_core #(
        .WIDTH(WIDTH)
    ) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .load      (accept && md_is_div(op)),
        .step      ((state_reg == ST_DIV) && !annul),
        .dividend  (a_abs),
        .divisor   (b_abs),
        .last      (div_last),
        .quotient  (div_q),
        .remainder (div_r)
    );

    // Divide by zero returns all-ones quotient and the original dividend, whatever the signedness.
    always_comb begin
        q_final = b_zero_reg ? '1    : (q_neg_reg ? -div_q : div_q);
        r_final = b_zero_reg ? a_reg : (a_neg_reg ? -div_r : div_r);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            a_reg         <= '0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            a_neg_reg     <= 1'b0;
            q_neg_reg     <= 1'b0;
            b_zero_reg    <= 1'b0;
            res_valid_reg <= 1'b0;
            mul_cnt_reg   <= '0;
        end else begin
            res_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        a_reg      <= a;
                        a_neg_reg  <= signed_op & a[WIDTH-1];
                        q_neg_reg  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        b_zero_reg <= (b == '0);
                        if (md_is_div(op)) begin
                            state_reg <= ST_DIV;
                        end else if (MUL_STAGES > 1) begin
                            state_reg   <= ST_MUL;
                            mul_cnt_reg <= '0;
                        end else begin
                            state_reg     <= ST_DONE;
                            hi_reg        <= prod_out[2*WIDTH-1:WIDTH];
                            lo_reg        <= prod_out[WIDTH-1:0];
                            res_valid_reg <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (annul) begin
                        state_reg <= ST_IDLE;
                    end else if (mul_cnt_reg == MUL_LAST) begin
                        state_reg     <= ST_DONE;
                        hi_reg        <= prod_out[2*WIDTH-1:WIDTH];
                        lo_reg        <= prod_out[WIDTH-1:0];
                        res_valid_reg <= 1'b1;
                    end else begin
                        mul_cnt_reg <= mul_cnt_reg + 1'b1;
                    end
                end
                ST_DIV: begin
                    if (annul) begin
                        state_reg <= ST_IDLE;
                    end else if (div_last) begin
                        state_reg     <= ST_DONE;
                        hi_reg        <= r_final;
                        lo_reg        <= q_final;
                        res_valid_reg <= 1'b1;
                    end
                end
                default: begin
                    // op_valid during DONE belongs to the retiring instruction.
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = !annul && (accept || state_reg == ST_MUL || state_reg == ST_DIV);
    assign res_valid = res_valid_reg;
    assign hi        = hi_reg;
    assign lo        = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: one instance with single-cycle multiply and one
// with a three-stage multiply, driven by shared inputs.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         op_valid;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         annul;

    logic         busy1, res_valid1, busy3, res_valid3;
    logic [W-1:0] hi1, lo1, hi3, lo3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W), .MUL_STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .a(a), .b(b),
        .annul(annul), .busy(busy1), .res_valid(res_valid1), .hi(hi1), .lo(lo1)
    );

    muldiv_unit #(.WIDTH(W), .MUL_STAGES(3)) dut3 (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .a(a), .b(b),
        .annul(annul), .busy(busy3), .res_valid(res_valid3), .hi(hi3), .lo(lo3)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Presents an op in cycle T, checks acceptance, then scrambles the operands
    // in T+1 so the DUT must use its latched copies. Returns in cycle T+1.
    task automatic issue(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        tick();
        annul = 1'b0; op_valid = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        check({tag, " busy@T"}, {31'b0, busy1}, 32'd1);
        tick();
        op_valid = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    endtask

    // Waits (bounded) for res_valid on dut1, checking latency and result.
    task automatic wait_res(input string tag, input int lat, input logic [W-1:0] exp_hi,
                            input logic [W-1:0] exp_lo);
        int n = 1;
        @(negedge clk);
        while (!res_valid1 && n < 60) begin
            tick();
            n++;
            @(negedge clk);
        end
        $display("%s: res_valid after %0d cycles hi=%h lo=%h", tag, n, hi1, lo1);
        check({tag, " latency"}, n, lat);
        check({tag, " hi"}, hi1, exp_hi);
        check({tag, " lo"}, lo1, exp_lo);
        check({tag, " busy@done"}, {31'b0, busy1}, 32'd0);
    endtask

    initial begin
        int pulses;
        rst = 1'b1; op_valid = 1'b0; op = 2'b00; a = '0; b = '0; annul = 1'b0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset busy", {31'b0, busy1}, 32'd0);
        check("reset res_valid", {31'b0, res_valid1}, 32'd0);
        check("reset hi", hi1, 32'd0);
        check("reset lo", lo1, 32'd0);

        // MUL -3 * 7, single-cycle multiply
        issue("mul", 2'b00, 32'hFFFF_FFFD, 32'd7);
        @(negedge clk);
        $display("mul: res_valid=%0b busy=%0b hi=%h lo=%h", res_valid1, busy1, hi1, lo1);
        check("mul res_valid@T+1", {31'b0, res_valid1}, 32'd1);
        check("mul busy@T+1", {31'b0, busy1}, 32'd0);
        check("mul hi", hi1, 32'hFFFF_FFFF);
        check("mul lo", lo1, 32'hFFFF_FFEB);
        idle(4);

        // MULU 0xFFFFFFFF * 2, three-stage multiply
        issue("mulu3", 2'b01, 32'hFFFF_FFFF, 32'd2);
        @(negedge clk);
        check("mulu3 busy@T+1", {31'b0, busy3}, 32'd1);
        check("mulu3 res_valid@T+1", {31'b0, res_valid3}, 32'd0);
        tick();
        @(negedge clk);
        check("mulu3 busy@T+2", {31'b0, busy3}, 32'd1);
        tick();
        @(negedge clk);
        $display("mulu3: res_valid=%0b busy=%0b hi=%h lo=%h", res_valid3, busy3, hi3, lo3);
        check("mulu3 res_valid@T+3", {31'b0, res_valid3}, 32'd1);
        check("mulu3 busy@T+3", {31'b0, busy3}, 32'd0);
        check("mulu3 hi", hi3, 32'd1);
        check("mulu3 lo", lo3, 32'hFFFF_FFFE);
        check("mulu1 hi", hi1, 32'd1);
        idle(4);

        issue("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_res("div -7/2", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue("divu 7/2", 2'b11, 32'd7, 32'd2);
        wait_res("divu 7/2", 33, 32'd1, 32'd3);
        issue("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_res("div ovf", 33, 32'd0, 32'h8000_0000);
        issue("div 100/-7", 2'b10, 32'd100, 32'hFFFF_FFF9);
        wait_res("div 100/-7", 33, 32'd2, 32'hFFFF_FFF2);
        issue("div -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0);
        wait_res("div -5/0", 33, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        issue("divu 5/0", 2'b11, 32'd5, 32'd0);
        wait_res("divu 5/0", 33, 32'd5, 32'hFFFF_FFFF);
        idle(2);

        // Annul a divide in T+10, then start a fresh one in T+11
        issue("annul div", 2'b10, 32'd1000, 32'd3);
        idle(9);
        annul = 1'b1;
        @(negedge clk);
        check("annul busy@T+10", {31'b0, busy1}, 32'd0);
        issue("after annul", 2'b11, 32'd100, 32'd7);
        check("annul hi kept", hi1, 32'd5);
        check("annul lo kept", lo1, 32'hFFFF_FFFF);
        wait_res("after annul", 33, 32'd2, 32'd14);
        idle(2);

        // op_valid held across DONE; new operands appear in DONE and start in DONE+1
        tick();
        op_valid = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7;
        tick();
        a = 32'd5; b = 32'd5;
        @(negedge clk);
        $display("hold: DONE res_valid=%0b busy=%0b lo=%h", res_valid1, busy1, lo1);
        check("hold res_valid@DONE", {31'b0, res_valid1}, 32'd1);
        check("hold busy@DONE", {31'b0, busy1}, 32'd0);
        check("hold lo 6*7", lo1, 32'd42);
        tick();
        @(negedge clk);
        check("b2b busy@DONE+1", {31'b0, busy1}, 32'd1);
        check("b2b res_valid@DONE+1", {31'b0, res_valid1}, 32'd0);
        tick();
        op_valid = 1'b0;
        @(negedge clk);
        $display("b2b: res_valid=%0b lo=%h", res_valid1, lo1);
        check("b2b res_valid", {31'b0, res_valid1}, 32'd1);
        check("b2b lo 5*5", lo1, 32'd25);
        idle(5);

        // Reset in the middle of a divide
        issue("rst div", 2'b10, 32'd77, 32'd5);
        idle(4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        $display("rst mid-div: busy=%0b res_valid=%0b hi=%h lo=%h", busy1, res_valid1, hi1, lo1);
        check("rst busy", {31'b0, busy1}, 32'd0);
        check("rst res_valid", {31'b0, res_valid1}, 32'd0);
        check("rst hi", hi1, 32'd0);
        check("rst lo", lo1, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            @(negedge clk);
            if (res_valid1) pulses++;
        end
        check("rst no late result", pulses, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
